// File: rtl/leaf_config_sequencer_pkg.sv
// rtl/leaf_config_sequencer_pkg.sv - packet layout, port constants, FSM encoding, packet builder
package leaf_config_sequencer_pkg;

  // BFT packet layout: {valid, leaf, port, zeros, payload}
  localparam int PACKET_BITS   = 49;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 3;
  localparam int NUM_PORT_BITS = 4;
  localparam int VALID_BIT     = PACKET_BITS - 1;
  localparam int LEAF_LSB      = VALID_BIT - NUM_LEAF_BITS;
  localparam int PORT_LSB      = LEAF_LSB - NUM_PORT_BITS;

  localparam int TABLE_DEPTH = 16;
  localparam int ADDR_BITS   = $clog2(TABLE_DEPTH);
  localparam int NUM_LEAVES  = 2 ** NUM_LEAF_BITS;
  localparam int CFG_BITS    = NUM_LEAF_BITS + PAYLOAD_BITS;

  localparam int unsigned DEFAULT_MAX_RETRY = 255;

  localparam logic [NUM_PORT_BITS-1:0] PORT_CONFIG = '0;
  localparam logic [NUM_PORT_BITS-1:0] PORT_START  = NUM_PORT_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_START_SCAN,
    ST_START_SEND,
    ST_FINISH
  } seq_state_e;

  function automatic logic [PACKET_BITS-1:0] build_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] pkt;
    pkt                              = '0;
    pkt[VALID_BIT]                   = 1'b1;
    pkt[LEAF_LSB +: NUM_LEAF_BITS]   = leaf;
    pkt[PORT_LSB +: NUM_PORT_BITS]   = port;
    pkt[PAYLOAD_BITS-1:0]            = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/leaf_config_sequencer_if.sv
// rtl/leaf_config_sequencer_if.sv - host register / BFT injection bundle for the sequencer
// master: host and BFT side (drives cfg_*, num_entries, start_leaf_mask, start, resend)
// slave:  sequencer side (drives dout_leaf_interface2bft, busy, done, error)
interface leaf_config_sequencer_if;
  import leaf_config_sequencer_pkg::*;

  logic                   cfg_wr_en;
  logic [ADDR_BITS-1:0]   cfg_wr_addr;
  logic [CFG_BITS-1:0]    cfg_wr_data;
  logic [ADDR_BITS:0]     num_entries;
  logic [NUM_LEAVES-1:0]  start_leaf_mask;
  logic                   start;
  logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
  logic                   resend;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, num_entries, start_leaf_mask, start, resend,
    input  dout_leaf_interface2bft, busy, done, error
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, num_entries, start_leaf_mask, start, resend,
    output dout_leaf_interface2bft, busy, done, error
  );

endinterface

// File: rtl/leaf_config_table.sv
// rtl/leaf_config_table.sv - configuration word RAM, one write port, registered read port
// clk_i: clock; wr_*: write port; rd_en_i/rd_addr_i: read request; rd_data_o: data one cycle later
module leaf_config_table
  import leaf_config_sequencer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [CFG_BITS-1:0]  wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [CFG_BITS-1:0]  rd_data_o
);

  // Contents survive reset so the host need not reload after an abort.
  logic [CFG_BITS-1:0] mem_q [TABLE_DEPTH];
  logic [CFG_BITS-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/leaf_config_sequencer.sv
// rtl/leaf_config_sequencer.sv - emits table config packets then per-leaf start packets into the BFT
// clk, reset: clock and synchronous active-high reset
// bus (slave): host config/start inputs, BFT packet output with resend back-pressure, status flags
module leaf_config_sequencer
  import leaf_config_sequencer_pkg::*;
#(
  parameter int unsigned MAX_RETRY = DEFAULT_MAX_RETRY
) (
  input logic                    clk,
  input logic                    reset,
  leaf_config_sequencer_if.slave bus
);

  localparam int RETRY_BITS = $clog2(MAX_RETRY + 1);
  localparam int IDX_BITS   = ADDR_BITS + 1;
  localparam int LP_BITS    = NUM_LEAF_BITS + 1;

  seq_state_e             state_q;
  logic [IDX_BITS-1:0]    idx_q;
  logic [IDX_BITS-1:0]    num_q;
  logic [NUM_LEAVES-1:0]  mask_q;
  logic [LP_BITS-1:0]     lp_q;
  logic [RETRY_BITS-1:0]  retry_q;
  logic [PACKET_BITS-1:0] dout_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;

  logic                   tbl_wr_en;
  logic                   tbl_rd_en;
  logic [ADDR_BITS-1:0]   tbl_rd_addr;
  logic [CFG_BITS-1:0]    tbl_rd_data;

  logic [IDX_BITS-1:0]      num_sat_d;
  logic [IDX_BITS-1:0]      idx_next_d;
  logic                     retry_exhausted_d;
  logic                     scan_found_d;
  logic [NUM_LEAF_BITS-1:0] scan_leaf_d;

  assign tbl_wr_en         = bus.cfg_wr_en && !busy_q;
  assign num_sat_d         = (bus.num_entries > IDX_BITS'(TABLE_DEPTH)) ? IDX_BITS'(TABLE_DEPTH)
                                                                        : bus.num_entries;
  assign idx_next_d        = idx_q + IDX_BITS'(1);
  assign retry_exhausted_d = (retry_q == RETRY_BITS'(MAX_RETRY - 1));

  // The read is launched on the edge that enters FETCH, so the word is
  // already in the RAM output register during FETCH and SEND can present
  // a registered packet one cycle later: two cycles per entry.
  always_comb begin
    tbl_rd_en   = 1'b0;
    tbl_rd_addr = idx_next_d[ADDR_BITS-1:0];
    case (state_q)
      ST_IDLE: begin
        tbl_rd_en   = bus.start;
        tbl_rd_addr = '0;
      end
      ST_SEND: tbl_rd_en = !bus.resend;
      default: tbl_rd_en = 1'b0;
    endcase
  end

  // Lowest set mask bit at or above the leaf pointer, found in one cycle so
  // sparse or empty masks do not cost a cycle per leaf.
  always_comb begin
    scan_found_d = 1'b0;
    scan_leaf_d  = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (mask_q[i] && (LP_BITS'(i) >= lp_q)) begin
        scan_found_d = 1'b1;
        scan_leaf_d  = NUM_LEAF_BITS'(i);
      end
    end
  end

  leaf_config_table u_table (
    .clk_i     (clk),
    .wr_en_i   (tbl_wr_en),
    .wr_addr_i (bus.cfg_wr_addr),
    .wr_data_i (bus.cfg_wr_data),
    .rd_en_i   (tbl_rd_en),
    .rd_addr_i (tbl_rd_addr),
    .rd_data_o (tbl_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      lp_q    <= '0;
      retry_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_q <= '0;
          done_q <= 1'b0;
          if (bus.start) begin
            num_q   <= num_sat_d;
            mask_q  <= bus.start_leaf_mask;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            lp_q    <= '0;
            retry_q <= '0;
            state_q <= (num_sat_d != '0) ? ST_FETCH : ST_START_SCAN;
          end
        end

        ST_FETCH: begin
          dout_q  <= build_packet(tbl_rd_data[CFG_BITS-1:PAYLOAD_BITS], PORT_CONFIG,
                                  tbl_rd_data[PAYLOAD_BITS-1:0]);
          retry_q <= '0;
          state_q <= ST_SEND;
        end

        ST_SEND: begin
          if (bus.resend) begin
            if (retry_exhausted_d) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              dout_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              retry_q <= retry_q + RETRY_BITS'(1);
            end
          end else begin
            dout_q  <= '0;
            retry_q <= '0;
            idx_q   <= idx_next_d;
            state_q <= (idx_next_d == num_q) ? ST_START_SCAN : ST_FETCH;
          end
        end

        ST_START_SCAN: begin
          if (scan_found_d) begin
            lp_q    <= {1'b0, scan_leaf_d};
            dout_q  <= build_packet(scan_leaf_d, PORT_START, PAYLOAD_BITS'(1));
            retry_q <= '0;
            state_q <= ST_START_SEND;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end

        ST_START_SEND: begin
          if (bus.resend) begin
            if (retry_exhausted_d) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              dout_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              retry_q <= retry_q + RETRY_BITS'(1);
            end
          end else begin
            dout_q  <= '0;
            retry_q <= '0;
            lp_q    <= lp_q + LP_BITS'(1);
            state_q <= ST_START_SCAN;
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.busy                    = busy_q;
  assign bus.done                    = done_q;
  assign bus.error                   = error_q;

endmodule

// File: tb/tb_leaf_config_sequencer.sv
// tb/tb_leaf_config_sequencer.sv - directed vector bench for leaf_config_sequencer
module tb_leaf_config_sequencer;

  typedef struct {
    logic [2:0]  leaf;
    logic [31:0] payload;
    logic [48:0] exp;
  } vec_t;

  logic clk;
  logic reset;

  leaf_config_sequencer_if bus();

  leaf_config_sequencer #(.MAX_RETRY(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        vecs[5];
  int          n_vec;
  int          n_miss;
  logic [48:0] acc[$];
  int          valid_cnt, hold_cnt, hold_bad, busy_cnt, done_cnt, overlap_bad;
  bit          prev_held;
  logic [48:0] prev_pkt;
  bit          last_done, last_error;
  int          run_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc.delete();
    valid_cnt = 0; hold_cnt = 0; hold_bad = 0; busy_cnt = 0; done_cnt = 0; overlap_bad = 0;
    prev_held = 1'b0; prev_pkt = '0;
  endtask

  task automatic sample();
    logic [48:0] cur;
    cur = bus.dout_leaf_interface2bft;
    if (cur[48]) valid_cnt++;
    if (cur[48] && !bus.resend) acc.push_back(cur);
    if (cur[48] && bus.resend) hold_cnt++;
    if (prev_held && cur !== prev_pkt) hold_bad++;
    prev_held = cur[48] && bus.resend;
    prev_pkt  = cur;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.done && bus.busy) overlap_bad++;
    last_done  = bus.done;
    last_error = bus.error;
  endtask

  // Inputs change at posedge+1, outputs are observed at the negedge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [2:0] leaf, input logic [31:0] payload);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = addr;
    bus.cfg_wr_data = {leaf, payload};
    step();
    bus.cfg_wr_en   = 1'b0;
  endtask

  // hold_on: accepted-packet index whose presentation gets resend for hold_len cycles
  // poke_at: loop cycle at which start and a table write are pulsed while busy
  task automatic run(input logic [4:0] num, input logic [7:0] mask, input int hold_on,
                     input int hold_len, input int poke_at, input int budget);
    int cyc;
    int hold_left;
    bit fin;
    clear_mon();
    bus.num_entries     = num;
    bus.start_leaf_mask = mask;
    bus.start           = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0; hold_left = hold_len; fin = 1'b0;
    while (!fin && cyc < budget) begin
      bus.resend = (hold_left > 0) && bus.dout_leaf_interface2bft[48] && (acc.size() == hold_on);
      if (cyc == poke_at) begin
        bus.start       = 1'b1;
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 4'd1;
        bus.cfg_wr_data = {3'd7, 32'h1234_5678};
      end
      step();
      bus.start     = 1'b0;
      bus.cfg_wr_en = 1'b0;
      if (bus.resend) hold_left--;
      cyc++;
      fin = last_done || last_error;
    end
    bus.resend = 1'b0;
    run_cycles = cyc;
    chk("run_finished", 64'(fin), 64'd1);
    repeat (3) step();
  endtask

  task automatic check_seq(input string tag);
    logic [48:0] got;
    chk({tag, "_count"}, 64'(acc.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      got = '1;
      if (i < acc.size()) got = acc[i];
      chk($sformatf("%s_pkt%0d", tag, i), 64'(got), 64'(vecs[i].exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_vec = 0; n_miss = 0;
    last_done = 1'b0; last_error = 1'b0;
    clear_mon();

    // entries 0..2 are table contents, 3..4 the start packets for mask 8'b0010_0100
    vecs[0] = '{3'd2, 32'hA5A5_0001, 49'h1_4000_A5A5_0001};
    vecs[1] = '{3'd5, 32'h0000_0002, 49'h1_A000_0000_0002};
    vecs[2] = '{3'd7, 32'hDEAD_BEEF, 49'h1_E000_DEAD_BEEF};
    vecs[3] = '{3'd2, 32'h0000_0001, 49'h1_4200_0000_0001};
    vecs[4] = '{3'd5, 32'h0000_0001, 49'h1_A200_0000_0001};

    reset = 1'b1;
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
    bus.num_entries = '0; bus.start_leaf_mask = '0; bus.start = 1'b0; bus.resend = 1'b0;
    repeat (3) step();
    chk("reset_dout",  64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("reset_busy",  64'(bus.busy),  64'd0);
    chk("reset_done",  64'(bus.done),  64'd0);
    chk("reset_error", 64'(bus.error), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++) write_entry(4'(i), vecs[i].leaf, vecs[i].payload);

    // plain sequence
    run(5'd3, 8'b0010_0100, -1, 0, -1, 200);
    check_seq("t1");
    chk("t1_done_cnt",  64'(done_cnt),    64'd1);
    chk("t1_busy_cyc",  64'(busy_cnt),    64'd11);
    chk("t1_done_busy", 64'(overlap_bad), 64'd0);
    chk("t1_valid_cnt", 64'(valid_cnt),   64'd5);

    // resend held for 4 cycles on the second packet
    run(5'd3, 8'b0010_0100, 1, 4, -1, 200);
    check_seq("t2");
    chk("t2_hold_cnt",  64'(hold_cnt),  64'd4);
    chk("t2_hold_stab", 64'(hold_bad),  64'd0);
    chk("t2_done_cnt",  64'(done_cnt),  64'd1);
    chk("t2_valid_cnt", 64'(valid_cnt), 64'd9);
    chk("t2_busy_cyc",  64'(busy_cnt),  64'd15);

    // nothing to send
    run(5'd0, 8'b0000_0000, -1, 0, -1, 50);
    chk("t3_latency_le3", 64'(run_cycles <= 3), 64'd1);
    chk("t3_done_cnt",    64'(done_cnt),        64'd1);
    chk("t3_valid_cnt",   64'(valid_cnt),       64'd0);

    // stuck link: abort after MAX_RETRY resends, then recover
    run(5'd3, 8'b0010_0100, 0, 1000, -1, 100);
    chk("t4_hold_cnt", 64'(hold_cnt), 64'd8);
    chk("t4_error",    64'(bus.error), 64'd1);
    chk("t4_busy",     64'(bus.busy),  64'd0);
    chk("t4_dout",     64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt),  64'd0);
    chk("t4_accepted", 64'(acc.size()), 64'd0);
    run(5'd3, 8'b0010_0100, -1, 0, -1, 200);
    chk("t4_error_clr", 64'(bus.error), 64'd0);
    chk("t4_done_re",   64'(done_cnt),  64'd1);
    check_seq("t4");

    // reset during START_SEND
    clear_mon();
    bus.num_entries = 5'd3; bus.start_leaf_mask = 8'b0010_0100; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.dout_leaf_interface2bft[48] && bus.dout_leaf_interface2bft[41]) && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t5_in_start_send", 64'(bus.dout_leaf_interface2bft[48] && bus.dout_leaf_interface2bft[41]), 64'd1);
    reset = 1'b1;
    step();
    chk("t5_dout",  64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("t5_busy",  64'(bus.busy),  64'd0);
    chk("t5_done",  64'(bus.done),  64'd0);
    chk("t5_error", 64'(bus.error), 64'd0);
    reset = 1'b0;
    step();
    run(5'd3, 8'b0010_0100, -1, 0, -1, 200);
    check_seq("t5");

    // start and table write while busy are ignored
    run(5'd3, 8'b0010_0100, -1, 0, 3, 200);
    check_seq("t6");
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
    chk("t6_busy_cyc", 64'(busy_cnt), 64'd11);
    run(5'd3, 8'b0010_0100, -1, 0, -1, 200);
    check_seq("t6_readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
